// File: rtl/stopwatch_timer_pkg.sv
// Shared definitions for the stopwatch/countdown time-keeping core.
// Holds the control state encoding, the byte offsets of the packed
// {hour, min, sec, sub} time word and the fixed sec/min moduli.
package stopwatch_timer_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_PAUSE = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam int FIELD_W  = 8;
    localparam int SUB_LSB  = 0;
    localparam int SEC_LSB  = 8;
    localparam int MIN_LSB  = 16;
    localparam int HOUR_LSB = 24;

    localparam int SEC_MOD  = 60;
    localparam int MIN_MOD  = 60;

endpackage

// File: rtl/stopwatch_timer_lap_fifo.sv
// lap_fifo: synchronous show-ahead FIFO for captured lap times.
// The head entry is held in a register so rd_data is a clean flop output;
// it shows a freshly pushed word on the edge after the push when empty,
// and the next entry on the edge after a pop.
// Ports:
//   clk, rst_n  - clock, asynchronous active-low reset
//   flush       - synchronous empty (pointers and count to zero)
//   push, pop   - write / read requests; push while full is dropped unless
//                 a pop happens in the same cycle, pop while empty is ignored
//   wr_data     - word to store
//   rd_data     - head entry (zero when empty)
//   count       - number of stored entries
//   full, empty - occupancy flags
module lap_fifo #(
    parameter int WIDTH = 32,
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     flush,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     full,
    output logic                     empty
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [AW-1:0]    rd_ptr_nx;
    logic [AW:0]      cnt;
    logic [AW:0]      cnt_nx;
    logic [WIDTH-1:0] head;
    logic [WIDTH-1:0] head_nx;
    logic             do_push;
    logic             do_pop;

    assign full  = (cnt == (AW+1)'(DEPTH));
    assign empty = (cnt == '0);

    assign do_pop  = pop && !empty;
    // A pop frees a slot in the same cycle, so a full FIFO still accepts.
    assign do_push = push && (!full || do_pop);

    always_comb begin
        rd_ptr_nx = do_pop ? rd_ptr + AW'(1) : rd_ptr;

        cnt_nx = cnt;
        if (do_push && !do_pop) begin
            cnt_nx = cnt + (AW+1)'(1);
        end else if (!do_push && do_pop) begin
            cnt_nx = cnt - (AW+1)'(1);
        end

        // The new head is the word being written only when it lands in the
        // slot the read pointer is about to point at (push into an empty or
        // just-emptied FIFO); otherwise it is already in memory.
        head_nx = '0;
        if (cnt_nx != '0) begin
            if (do_push && (wr_ptr == rd_ptr_nx)) begin
                head_nx = wr_data;
            end else begin
                head_nx = mem[rd_ptr_nx];
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else if (flush) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
            head   <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + AW'(1);
            end
            rd_ptr <= rd_ptr_nx;
            cnt    <= cnt_nx;
            head   <= head_nx;
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    assign rd_data = head;
    assign count   = cnt;

endmodule

// File: rtl/stopwatch_timer_core.sv
// stopwatch_timer_core: up/down time-keeping core with preset load,
// countdown expiry and a lap-capture FIFO.
// Ports:
//   clk, rst_n         - clock, asynchronous active-low reset
//   i_start / i_stop   - pulses: IDLE/PAUSE -> RUN, RUN -> PAUSE
//   i_clear            - pulse: zero time, flush laps, go IDLE
//   i_load/i_load_time - pulse + preset {hour, min, sec, sub}, fields clamped
//   i_dir              - level: 0 count up, 1 count down
//   i_lap / i_lap_rd   - capture o_time into the lap FIFO / pop its head
//   o_time             - {hour, min, sec, sub}, one byte per field
//   o_running          - state is RUN
//   o_expired          - one-cycle pulse when a countdown reaches zero
//   o_lap_data/valid   - lap FIFO head and not-empty flag
//   o_lap_count        - stored laps
//   o_lap_overflow     - sticky: a lap was dropped on a full FIFO
module stopwatch_timer_core
    import stopwatch_timer_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 100_000_000,
    parameter int TICK_HZ     = 100,
    parameter int HOUR_MAX    = 24,
    parameter int LAP_DEPTH   = 4
) (
    input  logic                         clk,
    input  logic                         rst_n,
    input  logic                         i_start,
    input  logic                         i_stop,
    input  logic                         i_clear,
    input  logic                         i_load,
    input  logic [31:0]                  i_load_time,
    input  logic                         i_dir,
    input  logic                         i_lap,
    input  logic                         i_lap_rd,
    output logic [31:0]                  o_time,
    output logic                         o_running,
    output logic                         o_expired,
    output logic [31:0]                  o_lap_data,
    output logic                         o_lap_valid,
    output logic [$clog2(LAP_DEPTH):0]   o_lap_count,
    output logic                         o_lap_overflow
);

    localparam int DIV   = CLK_FREQ_HZ / TICK_HZ;
    localparam int PRE_W = (DIV > 1) ? $clog2(DIV) : 1;

    localparam logic [PRE_W-1:0]   PRE_TOP  = PRE_W'(DIV - 1);
    localparam logic [FIELD_W-1:0] SUB_TOP  = FIELD_W'(TICK_HZ - 1);
    localparam logic [FIELD_W-1:0] SEC_TOP  = FIELD_W'(SEC_MOD - 1);
    localparam logic [FIELD_W-1:0] MIN_TOP  = FIELD_W'(MIN_MOD - 1);
    localparam logic [FIELD_W-1:0] HOUR_TOP = FIELD_W'(HOUR_MAX - 1);

    function automatic logic [FIELD_W-1:0] clamp_field(
        input logic [FIELD_W-1:0] value,
        input logic [FIELD_W-1:0] top
    );
        return (value > top) ? top : value;
    endfunction

    state_t             state_q, state_d;
    logic [PRE_W-1:0]   pre_q, pre_d;
    logic [FIELD_W-1:0] sub_q, sec_q, min_q, hour_q;
    logic [FIELD_W-1:0] sub_d, sec_d, min_d, hour_d;
    logic               expired_q, expired_d;
    logic               running_q;
    logic               overflow_q, overflow_d;

    logic               time_zero;
    logic               up_c0, up_c1, up_c2;
    logic               dn_b0, dn_b1, dn_b2;
    logic [FIELD_W-1:0] up_sub, up_sec, up_min, up_hour;
    logic [FIELD_W-1:0] dn_sub, dn_sec, dn_min, dn_hour;
    logic               dn_zero;

    logic               lap_push;
    logic               lap_pop;
    logic               fifo_full;
    logic               fifo_empty;

    assign time_zero = ({hour_q, min_q, sec_q, sub_q} == '0);

    // Up cascade: each field advances when every lower field wraps.
    assign up_c0   = (sub_q == SUB_TOP);
    assign up_c1   = up_c0 && (sec_q == SEC_TOP);
    assign up_c2   = up_c1 && (min_q == MIN_TOP);
    assign up_sub  = up_c0 ? '0 : sub_q + 8'd1;
    assign up_sec  = up_c0 ? ((sec_q == SEC_TOP) ? '0 : sec_q + 8'd1) : sec_q;
    assign up_min  = up_c1 ? ((min_q == MIN_TOP) ? '0 : min_q + 8'd1) : min_q;
    assign up_hour = up_c2 ? ((hour_q == HOUR_TOP) ? '0 : hour_q + 8'd1) : hour_q;

    // Down cascade: a field at zero reloads its top value and borrows upward.
    assign dn_b0   = (sub_q == '0);
    assign dn_b1   = dn_b0 && (sec_q == '0);
    assign dn_b2   = dn_b1 && (min_q == '0);
    assign dn_sub  = dn_b0 ? SUB_TOP : sub_q - 8'd1;
    assign dn_sec  = dn_b0 ? ((sec_q == '0) ? SEC_TOP : sec_q - 8'd1) : sec_q;
    assign dn_min  = dn_b1 ? ((min_q == '0) ? MIN_TOP : min_q - 8'd1) : min_q;
    assign dn_hour = dn_b2 ? ((hour_q == '0) ? HOUR_TOP : hour_q - 8'd1) : hour_q;
    assign dn_zero = ({dn_hour, dn_min, dn_sec, dn_sub} == '0);

    always_comb begin
        state_d   = state_q;
        pre_d     = pre_q;
        sub_d     = sub_q;
        sec_d     = sec_q;
        min_d     = min_q;
        hour_d    = hour_q;
        expired_d = 1'b0;

        if (i_clear) begin
            state_d = ST_IDLE;
            pre_d   = '0;
            sub_d   = '0;
            sec_d   = '0;
            min_d   = '0;
            hour_d  = '0;
        end else if (i_load && (state_q != ST_RUN)) begin
            sub_d  = clamp_field(i_load_time[SUB_LSB  +: FIELD_W], SUB_TOP);
            sec_d  = clamp_field(i_load_time[SEC_LSB  +: FIELD_W], SEC_TOP);
            min_d  = clamp_field(i_load_time[MIN_LSB  +: FIELD_W], MIN_TOP);
            hour_d = clamp_field(i_load_time[HOUR_LSB +: FIELD_W], HOUR_TOP);
            pre_d  = '0;
            if (state_q == ST_DONE) begin
                state_d = ST_IDLE;
            end
        end else begin
            unique case (state_q)
                ST_IDLE, ST_PAUSE: begin
                    // A coincident stop suppresses the start.
                    if (i_start && !i_stop) begin
                        state_d = ST_RUN;
                    end
                end
                ST_RUN: begin
                    if (i_stop) begin
                        state_d = ST_PAUSE;
                    end else if (i_dir && time_zero) begin
                        // Counting down from zero expires immediately.
                        state_d   = ST_DONE;
                        expired_d = 1'b1;
                    end else if (pre_q == PRE_TOP) begin
                        pre_d = '0;
                        if (!i_dir) begin
                            sub_d  = up_sub;
                            sec_d  = up_sec;
                            min_d  = up_min;
                            hour_d = up_hour;
                        end else begin
                            sub_d  = dn_sub;
                            sec_d  = dn_sec;
                            min_d  = dn_min;
                            hour_d = dn_hour;
                            if (dn_zero) begin
                                state_d   = ST_DONE;
                                expired_d = 1'b1;
                            end
                        end
                    end else begin
                        pre_d = pre_q + PRE_W'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    // Laps are not taken in IDLE and a clear outranks any lap activity.
    assign lap_push = i_lap && (state_q != ST_IDLE) && !i_clear;
    assign lap_pop  = i_lap_rd && !i_clear;

    always_comb begin
        overflow_d = overflow_q;
        if (i_clear) begin
            overflow_d = 1'b0;
        end else if (lap_push && fifo_full && !(lap_pop && !fifo_empty)) begin
            overflow_d = 1'b1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= ST_IDLE;
            pre_q      <= '0;
            sub_q      <= '0;
            sec_q      <= '0;
            min_q      <= '0;
            hour_q     <= '0;
            expired_q  <= 1'b0;
            running_q  <= 1'b0;
            overflow_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            pre_q      <= pre_d;
            sub_q      <= sub_d;
            sec_q      <= sec_d;
            min_q      <= min_d;
            hour_q     <= hour_d;
            expired_q  <= expired_d;
            running_q  <= (state_d == ST_RUN);
            overflow_q <= overflow_d;
        end
    end

    lap_fifo #(
        .WIDTH (32),
        .DEPTH (LAP_DEPTH)
    ) u_lap_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .flush   (i_clear),
        .push    (lap_push),
        .pop     (lap_pop),
        .wr_data (o_time),
        .rd_data (o_lap_data),
        .count   (o_lap_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign o_time         = {hour_q, min_q, sec_q, sub_q};
    assign o_running      = running_q;
    assign o_expired      = expired_q;
    assign o_lap_valid    = !fifo_empty;
    assign o_lap_overflow = overflow_q;

endmodule

// File: doc/stopwatch_timer_core.md
# stopwatch_timer_core

Parametrised successor to the fixed 100 Hz stopwatch/watch datapaths: one time-keeping core that counts up (stopwatch) or down (countdown timer) from a configurable tick rate. It adds preset load, countdown expiry and a lap-capture FIFO. It sits between the button/switch control units and the display mux, and drives a packed 32-bit time word in the existing {hour, min, sec, sub} byte format.

## Interface
- CLK_FREQ_HZ, 100_000_000, input clock frequency.
- TICK_HZ, 100, sub-second field rate and modulus; range 2..256.
- HOUR_MAX, 24, hour field modulus; range 2..256.
- LAP_DEPTH, 4, lap FIFO entries; power of two, ≥2.
- clk  in  1  system clock; single clock domain.
- rst_n  in  1  reset, asynchronous, active-low.
- i_start  in  1  one-cycle pulse: IDLE/PAUSE → RUN.
- i_stop  in  1  one-cycle pulse: RUN → PAUSE.
- i_clear  in  1  one-cycle pulse: zero the time, flush the FIFO, go to IDLE.
- i_load  in  1  one-cycle pulse: load i_load_time.
- i_load_time  in  32  preset {hour, min, sec, sub}.
- i_dir  in  1  level; 0 = count up, 1 = count down.
- i_lap  in  1  one-cycle pulse: capture o_time into the FIFO.
- i_lap_rd  in  1  pop the FIFO head.
- o_time  out  32  {hour[31:24], min[23:16], sec[15:8], sub[7:0]}; each field zero-extended.
- o_running  out  1  high while the state is RUN.
- o_expired  out  1  one-cycle pulse on countdown reaching zero.
- o_lap_data  out  32  FIFO head (show-ahead).
- o_lap_valid  out  1  FIFO not empty.
- o_lap_count  out  $clog2(LAP_DEPTH)+1  number of stored laps.
- o_lap_overflow  out  1  sticky: a lap was dropped because the FIFO was full.

## Operation
- States: IDLE, RUN, PAUSE, DONE.
- Transitions:
  - IDLE/PAUSE + i_start → RUN.
  - RUN + i_stop → PAUSE.
  - A down-mode tick that reaches all-zero: RUN → DONE.
  - i_clear from any state → IDLE.
  - i_load from DONE → IDLE.
  - i_start in RUN/DONE is ignored. i_stop outside RUN is ignored.
- Same-cycle priority: i_clear > i_load > i_start/i_stop > tick > i_lap. If i_start and i_stop coincide, i_stop wins.
- i_load is accepted only in IDLE/PAUSE/DONE and ignored in RUN. Each out-of-range field is clamped to its modulus−1.
- Prescaler:
  - DIV = CLK_FREQ_HZ/TICK_HZ.
  - Counts only in RUN and holds its value in PAUSE, so resume keeps the fractional tick.
  - Zeroed by i_clear, i_load and reset.
  - A tick is the RUN cycle in which the prescaler equals DIV−1.
- Up-count on tick:
  - sub increments. Carry to the next field at TICK_HZ−1, 59, 59.
  - hour wraps HOUR_MAX−1 → 0, so all fields return to zero. No expiry in up mode.
- Down-count on tick:
  - Borrow chain mirrors the up-count; a field at 0 reloads modulus−1.
  - The tick that produces all-zero sets state DONE and pulses o_expired.
- Start in down mode with the time already zero: next edge goes to DONE with an o_expired pulse.
- i_dir is sampled on every tick; changing it mid-run takes effect on the next tick.
- Lap FIFO:
  - i_lap is accepted in RUN/PAUSE/DONE and pushes the o_time value present in the same cycle.
  - When full, the push is dropped and o_lap_overflow is set.
  - i_lap_rd with o_lap_valid pops; i_lap_rd on an empty FIFO is ignored.
  - Simultaneous push and pop while full: both happen, no overflow.
  - i_clear empties the FIFO and clears o_lap_overflow.

## Timing
- Reset values: state IDLE, o_time 0, o_running 0, o_expired 0, o_lap_valid 0, o_lap_count 0, o_lap_overflow 0, o_lap_data 0, prescaler 0.
- All outputs are registered.
- o_running rises on the edge that samples i_start.
- First time increment after start from prescaler 0 occurs on edge DIV (counted from the start edge).
- o_time, state and o_expired update on the same edge as the tick.
- A lap pushed on edge E is visible on o_lap_data/o_lap_valid after edge E when the FIFO was empty.
- o_lap_data updates on the edge after a pop.
- Reset mid-run returns to IDLE immediately (asynchronous) and loses the FIFO contents.

## Structure
- Shared package stopwatch_timer_pkg holds:
  - state encodings for IDLE, RUN, PAUSE, DONE;
  - field byte offsets (SUB_LSB=0, SEC_LSB=8, MIN_LSB=16, HOUR_LSB=24);
  - modulus constants 60 for sec and min.
- One sub-module, lap_fifo: synchronous show-ahead FIFO parameterised by WIDTH=32 and DEPTH, with count and full/empty flags.
- The prescaler and the field cascade stay inline.

## Test plan
Bench parameters: CLK_FREQ_HZ=1000, TICK_HZ=100 (DIV=10).
- Up count: start from reset with i_dir=0, run 6000 ticks → o_time=0x00010000 (1 min). Sub rolls from 99 to 0 with a sec carry.
- Pause/resume: start, stop after 15 cycles, idle 50 cycles, start, run 5 more cycles → sub=2. The prescaler fraction is kept.
- Countdown: load 0x00000102 and run with i_dir=1 → after 102 ticks o_time=0, a single o_expired pulse, state DONE, o_running=0. A further i_start is ignored.
- Hour wrap: load {HOUR_MAX−1, 59, 59, 99} and run up one tick → o_time=0 and o_expired stays 0.
- Lap FIFO (LAP_DEPTH=4): 5 laps at distinct times → count 4, overflow=1, head = first lap. 4 pops return the laps in order, then valid=0. i_clear clears overflow.
- Priority: i_clear, i_load and i_start in the same cycle while in RUN → state IDLE, o_time=0, FIFO empty.
